// File: rtl/hex_display_sequencer.sv
// Time-shares one byte-to-two-hex decoder between NUM_SRC 8-bit CPU observation taps.
// AUTO rotates sources with a dwell/blank-gap cadence; MANUAL holds a source and steps on a key.

module hex_key_debounce #(
  parameter int DEBOUNCE_CYCLES = 500_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic srst,
  input  logic key_n,
  output logic press
);

  localparam int DB_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

  logic            sync1_r;
  logic            sync2_r;
  logic            level_r;
  logic [DB_W-1:0] cnt_r;
  logic            press_r;
  logic            level_nxt_s;
  logic [DB_W-1:0] cnt_nxt_s;
  logic            press_nxt_s;

  // Level must disagree for DEBOUNCE_CYCLES consecutive clocks before it is accepted
  always_comb begin
    level_nxt_s = level_r;
    cnt_nxt_s   = cnt_r;
    press_nxt_s = 1'b0;
    if (sync2_r != level_r) begin
      if (cnt_r == DB_LAST) begin
        cnt_nxt_s   = {DB_W{1'b0}};
        level_nxt_s = sync2_r;
        press_nxt_s = sync2_r;
      end else begin
        cnt_nxt_s = cnt_r + DB_W'(1);
      end
    end else begin
      cnt_nxt_s = {DB_W{1'b0}};
    end
  end

  // Synchronizer, debounce state and press pulse; everything clears to "released"
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_r <= 1'b0;
      sync2_r <= 1'b0;
      level_r <= 1'b0;
      cnt_r   <= {DB_W{1'b0}};
      press_r <= 1'b0;
    end else if (srst) begin
      sync1_r <= 1'b0;
      sync2_r <= 1'b0;
      level_r <= 1'b0;
      cnt_r   <= {DB_W{1'b0}};
      press_r <= 1'b0;
    end else begin
      sync1_r <= ~key_n;
      sync2_r <= sync1_r;
      level_r <= level_nxt_s;
      cnt_r   <= cnt_nxt_s;
      press_r <= press_nxt_s;
    end
  end

  assign press = press_r;

endmodule

module hex_display_sequencer #(
  parameter int NUM_SRC         = 4,
  parameter int DWELL_CYCLES    = 50_000_000,
  parameter int GAP_CYCLES      = 5_000_000,
  parameter int DEBOUNCE_CYCLES = 500_000
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_SRC*8-1:0]       src_data,
  input  logic                       key_mode_n,
  input  logic                       key_step_n,
  output logic [7:0]                 disp_byte,
  output logic [$clog2(NUM_SRC)-1:0] src_idx,
  output logic                       blank,
  output logic                       manual_dp_n
);

  localparam int IDX_W   = $clog2(NUM_SRC);
  localparam int CNT_MAX = (DWELL_CYCLES > GAP_CYCLES) ? DWELL_CYCLES : GAP_CYCLES;
  localparam int CNT_W   = (CNT_MAX > 2) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {
    AUTO_SHOW = 2'd0,
    AUTO_GAP  = 2'd1,
    MANUAL    = 2'd2
  } state_t;

  function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] i);
    logic [IDX_W-1:0] r;
    if (i == IDX_W'(NUM_SRC - 1)) begin
      r = {IDX_W{1'b0}};
    end else begin
      r = i + IDX_W'(1);
    end
    return r;
  endfunction

  logic             rst_sync_r;
  logic             srst_s;
  logic             mode_evt_s;
  logic             step_evt_s;
  state_t           state_r;
  state_t           state_nxt_s;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_nxt_s;
  logic [IDX_W-1:0] idx_r;
  logic [IDX_W-1:0] idx_nxt_s;
  logic [7:0]       sel_s;
  logic             blank_s;
  logic             dp_n_s;

  // Release-side reset synchronizer; assertion stays asynchronous
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rst_sync_r <= 1'b0;
    end else begin
      rst_sync_r <= 1'b1;
    end
  end

  assign srst_s = ~rst_sync_r;

  hex_key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_mode_db (
    .clk   (clk),
    .rst_n (rst_n),
    .srst  (srst_s),
    .key_n (key_mode_n),
    .press (mode_evt_s)
  );

  hex_key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_step_db (
    .clk   (clk),
    .rst_n (rst_n),
    .srst  (srst_s),
    .key_n (key_step_n),
    .press (step_evt_s)
  );

  // Next state: a mode event outranks both gap expiry and a coincident step
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    idx_nxt_s   = idx_r;
    case (state_r)
      AUTO_SHOW: begin
        if (mode_evt_s) begin
          state_nxt_s = MANUAL;
          cnt_nxt_s   = {CNT_W{1'b0}};
        end else if (cnt_r == DWELL_LAST) begin
          state_nxt_s = AUTO_GAP;
          cnt_nxt_s   = {CNT_W{1'b0}};
        end else begin
          cnt_nxt_s = cnt_r + CNT_W'(1);
        end
      end
      AUTO_GAP: begin
        if (mode_evt_s) begin
          state_nxt_s = MANUAL;
          cnt_nxt_s   = {CNT_W{1'b0}};
        end else if (cnt_r == GAP_LAST) begin
          state_nxt_s = AUTO_SHOW;
          cnt_nxt_s   = {CNT_W{1'b0}};
          idx_nxt_s   = wrap_inc(idx_r);
        end else begin
          cnt_nxt_s = cnt_r + CNT_W'(1);
        end
      end
      MANUAL: begin
        cnt_nxt_s = {CNT_W{1'b0}};
        if (mode_evt_s) begin
          state_nxt_s = AUTO_SHOW;
        end else if (step_evt_s) begin
          idx_nxt_s = wrap_inc(idx_r);
        end else begin
          idx_nxt_s = idx_r;
        end
      end
      default: begin
        state_nxt_s = AUTO_SHOW;
        cnt_nxt_s   = {CNT_W{1'b0}};
        idx_nxt_s   = {IDX_W{1'b0}};
      end
    endcase
  end

  // Sequencer state, dwell/gap counter and the selected source index
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= AUTO_SHOW;
      cnt_r   <= {CNT_W{1'b0}};
      idx_r   <= {IDX_W{1'b0}};
    end else if (srst_s) begin
      state_r <= AUTO_SHOW;
      cnt_r   <= {CNT_W{1'b0}};
      idx_r   <= {IDX_W{1'b0}};
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
      idx_r   <= idx_nxt_s;
    end
  end

  // Source mux and display qualifiers, all derived from the same registered state
  always_comb begin
    sel_s = 8'h00;
    for (int i = 0; i < NUM_SRC; i++) begin
      sel_s = (idx_r == IDX_W'(i)) ? src_data[8*i +: 8] : sel_s;
    end
    blank_s = (state_r == AUTO_GAP);
    dp_n_s  = (state_r != MANUAL);
  end

  // Output register: byte, index, blank and dp update together on one edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      disp_byte   <= 8'h00;
      src_idx     <= {IDX_W{1'b0}};
      blank       <= 1'b1;
      manual_dp_n <= 1'b1;
    end else if (srst_s) begin
      disp_byte   <= 8'h00;
      src_idx     <= {IDX_W{1'b0}};
      blank       <= 1'b1;
      manual_dp_n <= 1'b1;
    end else begin
      disp_byte   <= blank_s ? 8'h00 : sel_s;
      src_idx     <= idx_r;
      blank       <= blank_s;
      manual_dp_n <= dp_n_s;
    end
  end

endmodule

// File: tb/tb_hex_display_sequencer.sv
// Directed bench for hex_display_sequencer with DWELL=4, GAP=2, DEBOUNCE=3, NUM_SRC=3.
// Cycle numbers count rising edges after reset release; outputs are sampled 1 time unit after each edge.

module tb_hex_display_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [23:0] src_data;
  logic        key_mode_n;
  logic        key_step_n;
  logic [7:0]  disp_byte;
  logic [1:0]  src_idx;
  logic        blank;
  logic        manual_dp_n;

  logic [7:0] srcv [3];
  int cyc;
  int n_cmp;
  int n_err;

  assign src_data = {srcv[2], srcv[1], srcv[0]};

  always #5 clk = ~clk;

  hex_display_sequencer #(
    .NUM_SRC(3), .DWELL_CYCLES(4), .GAP_CYCLES(2), .DEBOUNCE_CYCLES(3)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .src_data    (src_data),
    .key_mode_n  (key_mode_n),
    .key_step_n  (key_step_n),
    .disp_byte   (disp_byte),
    .src_idx     (src_idx),
    .blank       (blank),
    .manual_dp_n (manual_dp_n)
  );

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Expected word is {disp_byte, src_idx, blank, manual_dp_n}
  task automatic chk(input string tag, input logic [11:0] exp);
    logic [11:0] obs;
    obs = {disp_byte, src_idx, blank, manual_dp_n};
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s at cyc %0d: observed %h expected %h", tag, cyc, obs, exp);
    end
  endtask

  // AUTO cadence: 6 cycles per source (4 shown, 2 blank), first shown cycle at 'base'
  task automatic chk_auto(input int base, input int idx0, input int k_to);
    int p;
    int q;
    logic show;
    while (cyc < k_to) begin
      tick();
      p = cyc - base;
      q = (idx0 + p / 6) % 3;
      show = (p % 6) < 4;
      chk("auto", {show ? srcv[q] : 8'h00, 2'(q), ~show, 1'b1});
    end
  endtask

  task automatic chk_hold(input int idx, input int k_to);
    while (cyc < k_to) begin
      tick();
      chk("manual", {srcv[idx], 2'(idx), 1'b0, 1'b0});
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    cyc = 0;
    rst_n = 1'b0;
    key_mode_n = 1'b1;
    key_step_n = 1'b1;
    srcv[0] = 8'h12;
    srcv[1] = 8'hAB;
    srcv[2] = 8'h3C;
    repeat (3) tick();
    chk("reset", {8'h00, 2'd0, 1'b1, 1'b1});

    cyc = 0;
    rst_n = 1'b1;
    tick();
    chk("release_edge1", {8'h00, 2'd0, 1'b1, 1'b1});
    chk_auto(2, 0, 14);

    // Bouncy mode press: 1 low, 1 high, then 10 low
    key_mode_n = 1'b0;
    chk_auto(2, 0, 15);
    key_mode_n = 1'b1;
    chk_auto(2, 0, 16);
    key_mode_n = 1'b0;
    chk_auto(2, 0, 22);
    chk_hold(0, 26);
    key_mode_n = 1'b1;
    chk_hold(0, 73);

    for (int j = 0; j < 4; j++) begin
      key_step_n = 1'b0;
      chk_hold(j % 3, 73 + 16 * j + 6);
      key_step_n = 1'b1;
      chk_hold((j + 1) % 3, 73 + 16 * j + 16);
    end

    // Live source change while source 1 is shown
    srcv[1] = 8'h77;
    #2;
    chk("src_latency", {8'hAB, 2'd1, 1'b0, 1'b0});
    chk_hold(1, 140);

    // Mode and step in the same cycle
    key_mode_n = 1'b0;
    key_step_n = 1'b0;
    chk_hold(1, 146);
    key_mode_n = 1'b1;
    key_step_n = 1'b1;
    chk_auto(147, 1, 164);

    // Mode event lands on the gap expiry at cycle 170
    key_mode_n = 1'b0;
    chk_auto(147, 1, 170);
    key_mode_n = 1'b1;
    chk_hold(1, 180);

    key_mode_n = 1'b0;
    chk_hold(1, 186);
    key_mode_n = 1'b1;
    chk_auto(187, 1, 192);

    // Both keys half-debounced when reset hits mid-dwell
    key_mode_n = 1'b0;
    key_step_n = 1'b0;
    chk_auto(187, 1, 195);
    rst_n = 1'b0;
    #1;
    chk("reset_async", {8'h00, 2'd0, 1'b1, 1'b1});
    key_mode_n = 1'b1;
    key_step_n = 1'b1;
    repeat (3) tick();
    chk("reset_hold", {8'h00, 2'd0, 1'b1, 1'b1});

    cyc = 0;
    rst_n = 1'b1;
    tick();
    chk("rerelease_edge1", {8'h00, 2'd0, 1'b1, 1'b1});
    chk_auto(2, 0, 24);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
